// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_pkg;
   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned NUM_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } ptg_state_e;
endpackage

// File: rtl/phase_down_counter.sv
// Loadable saturating down-counter that times one high or low phase.
module phase_down_counter
   import pulse_train_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - ONE;
      end
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/pulse_train_gen.sv
// Generates P pulses of H' cycles high and L' cycles low on a registered output,
// with valid/ready request handshake, abort, and a one-cycle done strobe.
module pulse_train_gen
   import pulse_train_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned NUM_W = NUM_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   output logic             ready_o,
   input  logic [CNT_W-1:0] high_cycles_i,
   input  logic [CNT_W-1:0] low_cycles_i,
   input  logic [NUM_W-1:0] num_pulses_i,
   input  logic             abort_i,
   output logic             wave_o,
   output logic             busy_o,
   output logic             done_o
);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
   localparam logic [NUM_W-1:0] ONE_N = NUM_W'(1);

   ptg_state_e       state, state_nxt;
   logic             wave_q, wave_nxt;
   logic             done_q, done_nxt;
   logic [CNT_W-1:0] h_len, h_len_nxt;
   logic [CNT_W-1:0] l_len, l_len_nxt;
   logic [NUM_W-1:0] rem, rem_nxt;
   logic             ph_load, ph_en, ph_zero;
   logic [CNT_W-1:0] ph_load_val;
   logic [CNT_W-1:0] h_req, l_req;

   // Zero-length phases are stretched to one cycle so every edge is observable.
   assign h_req = (high_cycles_i == '0) ? ONE_C : high_cycles_i;
   assign l_req = (low_cycles_i  == '0) ? ONE_C : low_cycles_i;

   phase_down_counter #(.CNT_W(CNT_W)) u_phase (
      .clk      (clk),
      .reset    (reset),
      .load     (ph_load),
      .en       (ph_en),
      .load_val (ph_load_val),
      .zero     (ph_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         wave_q <= 1'b0;
         done_q <= 1'b0;
         h_len  <= '0;
         l_len  <= '0;
         rem    <= '0;
      end else begin
         state  <= state_nxt;
         wave_q <= wave_nxt;
         done_q <= done_nxt;
         h_len  <= h_len_nxt;
         l_len  <= l_len_nxt;
         rem    <= rem_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      wave_nxt    = wave_q;
      done_nxt    = 1'b0;
      h_len_nxt   = h_len;
      l_len_nxt   = l_len;
      rem_nxt     = rem;
      ph_load     = 1'b0;
      ph_en       = 1'b0;
      ph_load_val = '0;

      case (state)
         IDLE: begin
            wave_nxt = 1'b0;
            if (start_i) begin
               h_len_nxt = h_req;
               l_len_nxt = l_req;
               rem_nxt   = num_pulses_i;
               if (num_pulses_i == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt   = HIGH;
                  wave_nxt    = 1'b1;
                  ph_load     = 1'b1;
                  ph_load_val = h_req - ONE_C;
               end
            end
         end
         HIGH, LOW: begin
            if (abort_i) begin
               state_nxt = IDLE;
               wave_nxt  = 1'b0;
               h_len_nxt = '0;
               l_len_nxt = '0;
               rem_nxt   = '0;
               ph_load   = 1'b1;
            end else if (!ph_zero) begin
               ph_en = 1'b1;
            end else if (state == HIGH) begin
               state_nxt   = LOW;
               wave_nxt    = 1'b0;
               ph_load     = 1'b1;
               ph_load_val = l_len - ONE_C;
            end else if (rem > ONE_N) begin
               rem_nxt     = rem - ONE_N;
               state_nxt   = HIGH;
               wave_nxt    = 1'b1;
               ph_load     = 1'b1;
               ph_load_val = h_len - ONE_C;
            end else begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               rem_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            wave_nxt  = 1'b0;
         end
      endcase
   end

   assign ready_o = (state == IDLE);
   assign busy_o  = (state == HIGH) || (state == LOW);
   assign wave_o  = wave_q;
   assign done_o  = done_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: per-cycle reference model, a vector
// table of whole-train expectations, and hand sequences for abort/reset/back-to-back.
module tb_pulse_train_gen;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_i = 1'b0;
   logic       ready_o;
   logic [7:0] high_cycles_i = '0;
   logic [7:0] low_cycles_i = '0;
   logic [7:0] num_pulses_i = '0;
   logic       abort_i = 1'b0;
   logic       wave_o;
   logic       busy_o;
   logic       done_o;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model: a queue holding the future wave level for each remaining cycle.
   bit m_busy = 1'b0;
   bit m_wave = 1'b0;
   bit m_done = 1'b0;
   bit q[$];

   typedef struct {
      int unsigned h, l, p;
      int unsigned ones, rises, done_off;
   } vec_t;
   vec_t vecs[6];

   pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .ready_o       (ready_o),
      .high_cycles_i (high_cycles_i),
      .low_cycles_i  (low_cycles_i),
      .num_pulses_i  (num_pulses_i),
      .abort_i       (abort_i),
      .wave_o        (wave_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int unsigned hp, lp;
      if (reset) begin
         q.delete();
         m_busy = 1'b0; m_wave = 1'b0; m_done = 1'b0;
      end else if (m_busy) begin
         m_done = 1'b0;
         if (abort_i) begin
            q.delete();
            m_busy = 1'b0; m_wave = 1'b0;
         end else if (q.size() > 0) begin
            m_wave = q.pop_front();
         end else begin
            m_busy = 1'b0; m_wave = 1'b0; m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         m_wave = 1'b0;
         if (start_i) begin
            if (num_pulses_i == 0) begin
               m_done = 1'b1;
            end else begin
               hp = (high_cycles_i == 0) ? 1 : int'(high_cycles_i);
               lp = (low_cycles_i  == 0) ? 1 : int'(low_cycles_i);
               for (int unsigned i = 0; i < num_pulses_i; i++) begin
                  for (int unsigned j = 0; j < hp; j++) q.push_back(1'b1);
                  for (int unsigned j = 0; j < lp; j++) q.push_back(1'b0);
               end
               m_wave = q.pop_front();
               m_busy = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("wave_o", wave_o, m_wave);
      chk("done_o", done_o, m_done);
      chk("busy_o", busy_o, m_busy);
      chk("ready_o", ready_o, !m_busy);
   endtask

   task automatic set_req(input int unsigned h, input int unsigned l, input int unsigned p);
      high_cycles_i = 8'(h);
      low_cycles_i  = 8'(l);
      num_pulses_i  = 8'(p);
   endtask

   task automatic run_vec(input vec_t v);
      int unsigned ones, rises, doff, off;
      bit prev;
      set_req(v.h, v.l, v.p);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      off = 1; ones = 0; rises = 0; doff = 0; prev = 1'b0;
      if (wave_o) begin ones++; rises++; end
      prev = wave_o;
      if (done_o) doff = off;
      while (doff == 0 && off < 2000) begin
         // Requests arriving mid-train must be ignored.
         start_i = (m_busy && q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         set_req($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
         tick();
         off++;
         if (wave_o) ones++;
         if (wave_o && !prev) rises++;
         prev = wave_o;
         if (done_o) doff = off;
      end
      start_i = 1'b0;
      chk("vec_ones", ones, v.ones);
      chk("vec_rises", rises, v.rises);
      chk("vec_done_off", doff, v.done_off);
   endtask

   initial begin
      vecs[0] = '{h: 3,   l: 2, p: 2, ones: 6,   rises: 2, done_off: 11};
      vecs[1] = '{h: 0,   l: 0, p: 4, ones: 4,   rises: 4, done_off: 9};
      vecs[2] = '{h: 0,   l: 5, p: 0, ones: 0,   rises: 0, done_off: 1};
      vecs[3] = '{h: 1,   l: 1, p: 1, ones: 1,   rises: 1, done_off: 3};
      vecs[4] = '{h: 2,   l: 7, p: 3, ones: 6,   rises: 3, done_off: 28};
      vecs[5] = '{h: 255, l: 1, p: 1, ones: 255, rises: 1, done_off: 257};

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      chk("reset_ready", ready_o, 1);
      chk("reset_wave", wave_o, 0);
      reset = 1'b0;
      tick();

      for (int unsigned i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
         tick();
      end

      // Back-to-back: second request accepted in the first train's done cycle
      run_vec(vecs[0]);
      chk("b2b_ready_in_done", ready_o, 1);
      set_req(1, 1, 1);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("b2b_rise", wave_o, 1);
      tick();
      chk("b2b_low", wave_o, 0);
      tick();
      chk("b2b_done", done_o, 1);
      tick();

      // Abort on 2nd cycle of pulse 2's high phase
      set_req(5, 5, 3);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int unsigned i = 0; i < 11; i++) tick();
      chk("abort_pre_wave", wave_o, 1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_wave", wave_o, 0);
      chk("abort_ready", ready_o, 1);
      chk("abort_done", done_o, 0);
      for (int unsigned i = 0; i < 20; i++) tick();

      // Abort in IDLE does not block a simultaneous start
      set_req(2, 2, 1);
      start_i = 1'b1;
      abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      chk("idle_abort_start", busy_o, 1);
      for (int unsigned i = 0; i < 6; i++) tick();

      // Reset mid-LOW phase, then a fresh request
      set_req(4, 4, 3);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int unsigned i = 0; i < 5; i++) tick();
      chk("mid_low_wave", wave_o, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_busy", busy_o, 0);
      chk("rst_mid_ready", ready_o, 1);
      chk("rst_mid_done", done_o, 0);
      run_vec(vecs[0]);
      tick();

      // All-ones request: run a while, then abort
      set_req(255, 255, 255);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int unsigned i = 0; i < 1200; i++) tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();

      // Randomised traffic against the model
      for (int unsigned i = 0; i < 3000; i++) begin
         start_i = ($urandom_range(0, 9) < 3);
         abort_i = ($urandom_range(0, 99) < 4);
         reset   = ($urandom_range(0, 499) == 0);
         set_req($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         tick();
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      reset   = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
